// File: rtl/axi4lite_arbiter_if.sv
// AXI4-lite channel bundle shared by the core ports and the system bus.
interface axi4lite #(
  parameter int ALEN = 32,
  parameter int XLEN = 32
);
  logic            awvalid;
  logic            awready;
  logic [ALEN-1:0] awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [XLEN-1:0] wdata;
  logic [XLEN/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [ALEN-1:0] araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_arbiter.sv
// Two-to-one AXI4-lite arbiter: independent round-robin read and write
// channels, one outstanding transaction each, responses to the grantee.
module axi4lite_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input logic    clk,
  input logic    rst,
  axi4lite.slave  in0,
  axi4lite.slave  in1,
  axi4lite.master out
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic rgrant, rgrant_d, rlast, rlast_d;
  logic wgrant, wgrant_d, wlast, wlast_d;
  logic aw_done, aw_done_d, w_done, w_done_d;
  logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic req0_w, req1_w, aw_hs, w_hs;

  assign g_arvalid = rgrant ? in1.arvalid : in0.arvalid;
  assign g_rready  = rgrant ? in1.rready  : in0.rready;
  assign g_awvalid = wgrant ? in1.awvalid : in0.awvalid;
  assign g_wvalid  = wgrant ? in1.wvalid  : in0.wvalid;
  assign g_bready  = wgrant ? in1.bready  : in0.bready;
  assign req0_w    = in0.awvalid | in0.wvalid;
  assign req1_w    = in1.awvalid | in1.wvalid;
  assign aw_hs     = (w_state == W_XFER) & g_awvalid & ~aw_done & out.awready;
  assign w_hs      = (w_state == W_XFER) & g_wvalid & ~w_done & out.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      rgrant  <= 1'b0;
      wgrant  <= 1'b0;
      rlast   <= ~RESET_PRIO;
      wlast   <= ~RESET_PRIO;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      rgrant  <= rgrant_d;
      wgrant  <= wgrant_d;
      rlast   <= rlast_d;
      wlast   <= wlast_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
  end

  always_comb begin
    r_next      = r_state;
    rgrant_d    = rgrant;
    rlast_d     = rlast;
    out.arvalid = 1'b0;
    out.araddr  = '0;
    out.arprot  = '0;
    out.rready  = 1'b0;
    in0.arready = 1'b0;
    in0.rvalid  = 1'b0;
    in0.rdata   = '0;
    in0.rresp   = '0;
    in1.arready = 1'b0;
    in1.rvalid  = 1'b0;
    in1.rdata   = '0;
    in1.rresp   = '0;
    unique case (r_state)
      R_IDLE: begin
        if (in0.arvalid | in1.arvalid) begin
          // contended: whoever did not win last time
          rgrant_d = (in0.arvalid & in1.arvalid) ? ~rlast : in1.arvalid;
          r_next   = R_ADDR;
        end
      end
      R_ADDR: begin
        out.arvalid = g_arvalid;
        out.araddr  = rgrant ? in1.araddr : in0.araddr;
        out.arprot  = rgrant ? in1.arprot : in0.arprot;
        if (rgrant) in1.arready = out.arready;
        else        in0.arready = out.arready;
        if (g_arvalid & out.arready) r_next = R_DATA;
      end
      R_DATA: begin
        out.rready = g_rready;
        if (rgrant) begin
          in1.rvalid = out.rvalid;
          in1.rdata  = out.rdata;
          in1.rresp  = out.rresp;
        end else begin
          in0.rvalid = out.rvalid;
          in0.rdata  = out.rdata;
          in0.rresp  = out.rresp;
        end
        if (out.rvalid & g_rready) begin
          r_next  = R_IDLE;
          rlast_d = rgrant;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next      = w_state;
    wgrant_d    = wgrant;
    wlast_d     = wlast;
    aw_done_d   = aw_done | aw_hs;
    w_done_d    = w_done | w_hs;
    out.awvalid = 1'b0;
    out.awaddr  = '0;
    out.awprot  = '0;
    out.wvalid  = 1'b0;
    out.wdata   = '0;
    out.wstrb   = '0;
    out.bready  = 1'b0;
    in0.awready = 1'b0;
    in0.wready  = 1'b0;
    in0.bvalid  = 1'b0;
    in0.bresp   = '0;
    in1.awready = 1'b0;
    in1.wready  = 1'b0;
    in1.bvalid  = 1'b0;
    in1.bresp   = '0;
    unique case (w_state)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req0_w | req1_w) begin
          wgrant_d = (req0_w & req1_w) ? ~wlast : req1_w;
          w_next   = W_XFER;
        end
      end
      W_XFER: begin
        // a finished channel stays quiet until the burst completes
        out.awvalid = g_awvalid & ~aw_done;
        out.awaddr  = wgrant ? in1.awaddr : in0.awaddr;
        out.awprot  = wgrant ? in1.awprot : in0.awprot;
        out.wvalid  = g_wvalid & ~w_done;
        out.wdata   = wgrant ? in1.wdata : in0.wdata;
        out.wstrb   = wgrant ? in1.wstrb : in0.wstrb;
        if (wgrant) begin
          in1.awready = out.awready & ~aw_done;
          in1.wready  = out.wready & ~w_done;
        end else begin
          in0.awready = out.awready & ~aw_done;
          in0.wready  = out.wready & ~w_done;
        end
        if ((aw_done | aw_hs) & (w_done | w_hs)) w_next = W_RESP;
      end
      W_RESP: begin
        out.bready = g_bready;
        if (wgrant) begin
          in1.bvalid = out.bvalid;
          in1.bresp  = out.bresp;
        end else begin
          in0.bvalid = out.bvalid;
          in0.bresp  = out.bresp;
        end
        if (out.bvalid & g_bready) begin
          w_next  = W_IDLE;
          wlast_d = wgrant;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter; the bench plays both
// requesters and the system-bus slave.
module tb_axi4lite_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  axi4lite i0 ();
  axi4lite i1 ();
  axi4lite o ();

  axi4lite_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .in0(i0.slave),
    .in1(i1.slave),
    .out(o.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_all();
    i0.arvalid = 0; i0.araddr = 0; i0.arprot = 0; i0.rready = 0;
    i0.awvalid = 0; i0.awaddr = 0; i0.awprot = 0;
    i0.wvalid = 0; i0.wdata = 0; i0.wstrb = 0; i0.bready = 0;
    i1.arvalid = 0; i1.araddr = 0; i1.arprot = 0; i1.rready = 0;
    i1.awvalid = 0; i1.awaddr = 0; i1.awprot = 0;
    i1.wvalid = 0; i1.wdata = 0; i1.wstrb = 0; i1.bready = 0;
    o.arready = 0; o.rvalid = 0; o.rdata = 0; o.rresp = 0;
    o.awready = 0; o.wready = 0; o.bvalid = 0; o.bresp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // called at an idle-state negedge with port p requesting
  task automatic rd_xact(input bit p, input logic [31:0] a,
                         input logic [31:0] d, input bit drop);
    @(negedge clk);
    o.arready = 1'b1;
    #1;
    check("rd_arvalid", o.arvalid, 1);
    check("rd_araddr", o.araddr, a);
    check("rd_arready_g", p ? i1.arready : i0.arready, 1);
    check("rd_arready_ng", p ? i0.arready : i1.arready, 0);
    @(negedge clk);
    o.arready = 1'b0;
    o.rvalid  = 1'b1;
    o.rdata   = d;
    if (drop) begin
      if (p) i1.arvalid = 1'b0;
      else   i0.arvalid = 1'b0;
    end
    #1;
    check("rd_rvalid_g", p ? i1.rvalid : i0.rvalid, 1);
    check("rd_rdata_g", p ? i1.rdata : i0.rdata, d);
    check("rd_rvalid_ng", p ? i0.rvalid : i1.rvalid, 0);
    @(negedge clk);
    o.rvalid = 1'b0;
    o.rdata  = 0;
    #1;
    check("rd_idle_arvalid", o.arvalid, 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    clear_all();

    // reset state
    @(negedge clk);
    @(negedge clk);
    i0.arvalid = 1'b1;
    i1.awvalid = 1'b1;
    o.rvalid   = 1'b1;
    o.bvalid   = 1'b1;
    #1;
    check("rst_out_arvalid", o.arvalid, 0);
    check("rst_out_awvalid", o.awvalid, 0);
    check("rst_out_wvalid", o.wvalid, 0);
    check("rst_out_rready", o.rready, 0);
    check("rst_out_bready", o.bready, 0);
    check("rst_in0_arready", i0.arready, 0);
    check("rst_in0_rvalid", i0.rvalid, 0);
    check("rst_in1_awready", i1.awready, 0);
    check("rst_in1_bvalid", i1.bvalid, 0);

    // single read on in1, slave answers one cycle late
    do_reset();
    i1.arvalid = 1'b1;
    i1.araddr  = 32'h100;
    i1.rready  = 1'b1;
    #1;
    check("t1_idle_arvalid", o.arvalid, 0);
    @(negedge clk);
    #1;
    check("t1_arvalid", o.arvalid, 1);
    check("t1_araddr", o.araddr, 32'h100);
    o.arready = 1'b1;
    #1;
    check("t1_in1_arready", i1.arready, 1);
    @(negedge clk);
    i1.arvalid = 1'b0;
    o.arready  = 1'b0;
    #1;
    check("t1_wait_rvalid", i1.rvalid, 0);
    check("t1_rready", o.rready, 1);
    check("t1_arvalid_low", o.arvalid, 0);
    @(negedge clk);
    o.rvalid = 1'b1;
    o.rdata  = 32'hDEADBEEF;
    #1;
    check("t1_in1_rvalid", i1.rvalid, 1);
    check("t1_in1_rdata", i1.rdata, 32'hDEADBEEF);
    check("t1_in0_rvalid", i0.rvalid, 0);
    check("t1_in0_rdata", i0.rdata, 0);
    @(negedge clk);
    o.rvalid = 1'b0;
    #1;
    check("t1_done_rvalid", i1.rvalid, 0);

    // contended reads from reset: expect 0,1,0,1,...
    do_reset();
    i0.arvalid = 1'b1; i0.araddr = 32'h1000; i0.rready = 1'b1;
    i1.arvalid = 1'b1; i1.araddr = 32'h2000; i1.rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        rd_xact(1'b0, 32'h1000, 32'hA000_0000 + i, i >= 6);
      else
        rd_xact(1'b1, 32'h2000, 32'hB000_0000 + i, i >= 6);
    end

    // in0 read concurrent with in1 write
    do_reset();
    i0.arvalid = 1'b1; i0.araddr = 32'h300; i0.rready = 1'b1;
    i1.awvalid = 1'b1; i1.awaddr = 32'h40;
    i1.wvalid  = 1'b1; i1.wdata  = 32'h12345678; i1.wstrb = 4'hF;
    i1.bready  = 1'b1;
    @(negedge clk);
    #1;
    check("t3_arvalid", o.arvalid, 1);
    check("t3_araddr", o.araddr, 32'h300);
    check("t3_awvalid", o.awvalid, 1);
    check("t3_awaddr", o.awaddr, 32'h40);
    check("t3_wvalid", o.wvalid, 1);
    check("t3_wdata", o.wdata, 32'h12345678);
    check("t3_wstrb", o.wstrb, 4'hF);
    o.arready = 1'b1; o.awready = 1'b1; o.wready = 1'b1;
    #1;
    check("t3_in0_arready", i0.arready, 1);
    check("t3_in1_awready", i1.awready, 1);
    check("t3_in1_wready", i1.wready, 1);
    @(negedge clk);
    i0.arvalid = 1'b0; i1.awvalid = 1'b0; i1.wvalid = 1'b0;
    o.arready = 1'b0; o.awready = 1'b0; o.wready = 1'b0;
    o.rvalid = 1'b1; o.rdata = 32'h55;
    o.bvalid = 1'b1; o.bresp = 2'b00;
    #1;
    check("t3_in0_rdata", i0.rdata, 32'h55);
    check("t3_in1_bvalid", i1.bvalid, 1);
    check("t3_in1_bresp", i1.bresp, 2'b00);
    check("t3_in0_bvalid", i0.bvalid, 0);
    check("t3_awvalid_low", o.awvalid, 0);
    @(negedge clk);
    o.rvalid = 1'b0; o.bvalid = 1'b0;
    #1;
    check("t3_idle_bvalid", i1.bvalid, 0);
    check("t3_idle_rvalid", i0.rvalid, 0);

    // W before AW, B only after both handshakes
    do_reset();
    i1.wvalid = 1'b1; i1.wdata = 32'hCAFE; i1.wstrb = 4'h3;
    i1.bready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_wvalid", o.wvalid, 1);
    check("t4_awvalid", o.awvalid, 0);
    o.wready = 1'b1; o.awready = 1'b1;
    @(negedge clk);
    i1.wvalid = 1'b0;
    o.wready  = 1'b0;
    o.bvalid  = 1'b1; o.bresp = 2'b10;
    #1;
    check("t4_wvalid_done", o.wvalid, 0);
    check("t4_early_bvalid", i1.bvalid, 0);
    check("t4_early_bready", o.bready, 0);
    @(negedge clk);
    i1.wvalid  = 1'b1;
    i1.awvalid = 1'b1; i1.awaddr = 32'h80;
    #1;
    check("t4_wvalid_held", o.wvalid, 0);
    check("t4_awvalid_late", o.awvalid, 1);
    check("t4_awaddr", o.awaddr, 32'h80);
    check("t4_in1_awready", i1.awready, 1);
    check("t4_bvalid_xfer", i1.bvalid, 0);
    @(negedge clk);
    i1.awvalid = 1'b0; i1.wvalid = 1'b0;
    #1;
    check("t4_bvalid", i1.bvalid, 1);
    check("t4_bresp", i1.bresp, 2'b10);
    check("t4_bready", o.bready, 1);
    @(negedge clk);
    o.bvalid = 1'b0; o.bresp = 0; o.awready = 1'b0;
    #1;
    check("t4_idle_bvalid", i1.bvalid, 0);
    check("t4_idle_awvalid", o.awvalid, 0);

    // slave stalls AR for 5 cycles, requester stalls R for 3
    do_reset();
    i1.arvalid = 1'b1; i1.araddr = 32'h200; i1.rready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("t5_ar_hold_valid", o.arvalid, 1);
      check("t5_ar_hold_addr", o.araddr, 32'h200);
      check("t5_ar_hold_ready", i1.arready, 0);
    end
    @(negedge clk);
    o.arready = 1'b1;
    #1;
    check("t5_arready", i1.arready, 1);
    @(negedge clk);
    i1.arvalid = 1'b0;
    o.arready  = 1'b0;
    o.rvalid   = 1'b1; o.rdata = 32'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_r_hold_rready", o.rready, 0);
      check("t5_r_hold_rvalid", i1.rvalid, 1);
      check("t5_r_hold_rdata", i1.rdata, 32'h77);
      @(negedge clk);
    end
    i1.rready = 1'b1;
    #1;
    check("t5_rready", o.rready, 1);
    @(negedge clk);
    #1;
    check("t5_once_rvalid", i1.rvalid, 0);
    check("t5_once_arvalid", o.arvalid, 0);
    o.rvalid = 1'b0;

    // reset while in R_DATA, then a clean read
    do_reset();
    i0.arvalid = 1'b1; i0.araddr = 32'h10; i0.rready = 1'b1;
    @(negedge clk);
    o.arready = 1'b1;
    @(negedge clk);
    o.arready  = 1'b0;
    i0.arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o.rvalid = 1'b1; o.rdata = 32'hBAD;
    #1;
    check("t6_rvalid_drop", i0.rvalid, 0);
    check("t6_rready_drop", o.rready, 0);
    check("t6_arvalid_drop", o.arvalid, 0);
    o.rvalid = 1'b0; o.rdata = 0;
    i0.arvalid = 1'b1;
    rd_xact(1'b0, 32'h10, 32'h99, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
